// File: rtl/key_scan_if.sv
// Keypad scanner bus: column drive and row returns toward the pad,
// committed key code, valid strobe and held level toward decode logic.
interface key_scan_if;
    logic [4:0] key_in;
    logic [3:0] key_column_out;
    logic [4:0] key_code;
    logic       key_valid;
    logic       key_pressed;

    modport master (
        input  key_in,
        output key_column_out,
        output key_code,
        output key_valid,
        output key_pressed
    );

    modport slave (
        output key_in,
        input  key_column_out,
        input  key_code,
        input  key_valid,
        input  key_pressed
    );
endinterface

// File: rtl/key_scan.sv
// 4x5 matrix keypad scanner: active-low column walk, one row sample per
// column, per-frame single/multi-key classification and frame debounce.
module key_scan #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20
) (
    input  logic       clk,
    input  logic       rst,
    key_scan_if.master bus
);

    localparam logic [15:0] DWELL_LAST = 16'(SCAN_DIV - 1);
    localparam logic [7:0]  STABLE_MAX = 8'(DEBOUNCE_CNT);
    localparam logic [4:0]  MULTI_KEY  = 5'd31;

    logic [1:0]  col_reg;
    logic [15:0] dwell_reg;
    logic [3:0]  column_reg;
    logic [1:0]  acc_hits_reg;
    logic [4:0]  acc_code_reg;
    logic [4:0]  prev_reg;
    logic [7:0]  stable_reg;
    logic [4:0]  committed_reg;
    logic [4:0]  code_reg;
    logic        valid_reg;
    logic        pressed_reg;

    logic [4:0]  row_low;
    logic [4:0]  col_base;
    logic [4:0]  row_code [5];
    logic [1:0]  col_hits;
    logic [4:0]  col_code;
    logic [2:0]  hits_sum;
    logic [1:0]  hits_next;
    logic [4:0]  frame_code;
    logic [4:0]  frame_result;
    logic [7:0]  stable_next;
    logic        commit;
    logic        is_key;
    logic        sample;
    logic        frame_end;

    assign row_low   = ~bus.key_in;
    assign sample    = (dwell_reg == DWELL_LAST);
    assign frame_end = sample && (col_reg == 2'd3);

    always_comb begin
        case (col_reg)
            2'd0:    col_base = 5'd0;
            2'd1:    col_base = 5'd5;
            2'd2:    col_base = 5'd10;
            default: col_base = 5'd15;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_row_code
            assign row_code[gi] = col_base + 5'(gi) + 5'd1;
        end
    endgenerate

    // Hit counts saturate at 2: beyond "more than one" the number is irrelevant.
    always_comb begin
        col_hits = 2'd0;
        col_code = 5'd0;
        for (int r = 4; r >= 0; r--) begin
            if (row_low[r]) begin
                col_code = row_code[r];
                if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
            end
        end
        hits_sum   = {1'b0, acc_hits_reg} + {1'b0, col_hits};
        hits_next  = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
        frame_code = (acc_hits_reg != 2'd0) ? acc_code_reg : col_code;
        if (hits_next == 2'd0)      frame_result = 5'd0;
        else if (hits_next == 2'd1) frame_result = frame_code;
        else                        frame_result = MULTI_KEY;
        is_key = (frame_result != 5'd0) && (frame_result != MULTI_KEY);
    end

    // Commit only on the frame that brings the count up to the threshold.
    always_comb begin
        if (frame_result == prev_reg) begin
            stable_next = (stable_reg == STABLE_MAX) ? stable_reg : stable_reg + 8'd1;
            commit      = (stable_reg != STABLE_MAX) && (stable_reg + 8'd1 == STABLE_MAX);
        end else begin
            stable_next = 8'd1;
            commit      = (STABLE_MAX == 8'd1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_reg       <= 2'd0;
            dwell_reg     <= 16'd0;
            column_reg    <= 4'b1110;
            acc_hits_reg  <= 2'd0;
            acc_code_reg  <= 5'd0;
            prev_reg      <= 5'd0;
            stable_reg    <= 8'd0;
            committed_reg <= 5'd0;
            code_reg      <= 5'd0;
            valid_reg     <= 1'b0;
            pressed_reg   <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            if (sample) begin
                dwell_reg  <= 16'd0;
                col_reg    <= col_reg + 2'd1;
                column_reg <= {column_reg[2:0], column_reg[3]};
                if (frame_end) begin
                    acc_hits_reg <= 2'd0;
                    acc_code_reg <= 5'd0;
                    prev_reg     <= frame_result;
                    stable_reg   <= stable_next;
                    if (commit) begin
                        committed_reg <= frame_result;
                        if (!is_key) begin
                            pressed_reg <= 1'b0;
                        end else if (frame_result != committed_reg) begin
                            code_reg    <= frame_result;
                            valid_reg   <= 1'b1;
                            pressed_reg <= 1'b1;
                        end
                    end
                end else begin
                    acc_hits_reg <= hits_next;
                    acc_code_reg <= frame_code;
                end
            end else begin
                dwell_reg <= dwell_reg + 16'd1;
            end
        end
    end

    assign bus.key_column_out = column_reg;
    assign bus.key_code       = code_reg;
    assign bus.key_valid      = valid_reg;
    assign bus.key_pressed    = pressed_reg;

endmodule

// File: tb/tb_key_scan.sv
// Directed bench for key_scan: a keypad model closes keys from a mask,
// frame-by-frame vectors check column walk, strobe timing, code and level.
module tb_key_scan;
    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 3;
    localparam int FRAME        = 4 * SCAN_DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #50 clk = ~clk;

    key_scan_if bus ();

    key_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Keypad: mask bit (code-1) closed pulls its row low while its column is driven.
    logic [19:0] key_mask = '0;
    always_comb begin
        for (int r = 0; r < 5; r++) begin
            bus.key_in[r] = 1'b1;
            for (int c = 0; c < 4; c++)
                if (!bus.key_column_out[c] && key_mask[c*5+r]) bus.key_in[r] = 1'b0;
        end
    end

    typedef struct {
        logic [19:0] mask;
        bit          pulse;
        logic [4:0]  code;
        bit          pressed;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   passes = 0;
    int   frame_no = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    function automatic logic [19:0] k(input int code);
        logic [19:0] m;
        m = '0;
        m[code-1] = 1'b1;
        return m;
    endfunction

    task automatic add(input logic [19:0] mask, input bit pulse, input int code, input bit pressed);
        vec_t v;
        v.mask = mask; v.pulse = pulse; v.code = 5'(code); v.pressed = pressed;
        vecs.push_back(v);
    endtask

    task automatic run_frame(input vec_t v);
        logic [3:0] one;
        logic [3:0] exp_col;
        int pulses;
        one = 4'b0001;
        pulses = 0;
        key_mask = v.mask;
        frame_no++;
        for (int i = 1; i <= FRAME; i++) begin
            @(negedge clk);
            exp_col = ~(one << ((i / SCAN_DIV) % 4));
            chk($sformatf("column f%0d c%0d", frame_no, i), 32'(bus.key_column_out), 32'(exp_col));
            chk($sformatf("valid f%0d c%0d", frame_no, i), 32'(bus.key_valid),
                32'(v.pulse && (i == FRAME)));
            if (bus.key_valid) pulses++;
        end
        chk($sformatf("code f%0d", frame_no), 32'(bus.key_code), 32'(v.code));
        chk($sformatf("pressed f%0d", frame_no), 32'(bus.key_pressed), 32'(v.pressed));
        $display("frame %0d mask=%05h pulses=%0d code=%0d pressed=%0b", frame_no, v.mask,
                 pulses, bus.key_code, bus.key_pressed);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " column"},  32'(bus.key_column_out), 32'h0000000e);
        chk({tag, " code"},    32'(bus.key_code), 32'd0);
        chk({tag, " valid"},   32'(bus.key_valid), 32'd0);
        chk({tag, " pressed"}, 32'(bus.key_pressed), 32'd0);
    endtask

    initial begin
        // Idle frames: result 0 commits quietly.
        add('0, 0, 0, 0); add('0, 0, 0, 0); add('0, 0, 0, 0);
        // Key 13 (column 2 row 2) held 5 frames, then released 3 frames.
        add(k(13), 0, 0, 0);  add(k(13), 0, 0, 0);  add(k(13), 1, 13, 1);
        add(k(13), 0, 13, 1); add(k(13), 0, 13, 1);
        add('0, 0, 13, 1); add('0, 0, 13, 1); add('0, 0, 13, 0);
        // Key 1 bouncing in alternate frames, then stable.
        add(k(1), 0, 13, 0); add('0, 0, 13, 0); add(k(1), 0, 13, 0);
        add('0, 0, 13, 0);   add(k(1), 0, 13, 0); add('0, 0, 13, 0);
        add(k(1), 0, 13, 0); add(k(1), 0, 13, 0); add(k(1), 1, 1, 1);
        add('0, 0, 1, 1); add('0, 0, 1, 1); add('0, 0, 1, 0);
        // Rows 0 and 4 of column 0 together, then key 1 alone re-commits.
        add(k(1) | k(5), 0, 1, 0); add(k(1) | k(5), 0, 1, 0); add(k(1) | k(5), 0, 1, 0);
        add(k(1) | k(5), 0, 1, 0);
        add(k(1), 0, 1, 0); add(k(1), 0, 1, 0); add(k(1), 1, 1, 1);
        // Keys 6 and 16 in different columns, then key 7 press/release/press.
        add(k(6) | k(16), 0, 1, 1); add(k(6) | k(16), 0, 1, 1); add(k(6) | k(16), 0, 1, 0);
        add(k(7), 0, 1, 0); add(k(7), 0, 1, 0); add(k(7), 1, 7, 1);
        add('0, 0, 7, 1); add('0, 0, 7, 1); add('0, 0, 7, 0);
        add(k(7), 0, 7, 0); add(k(7), 0, 7, 0); add(k(7), 1, 7, 1);
        // One-frame glitch shorter than debounce: same key re-commits silently.
        add('0, 0, 7, 1); add(k(7), 0, 7, 1); add(k(7), 0, 7, 1); add(k(7), 0, 7, 1);
        add('0, 0, 7, 1); add('0, 0, 7, 1); add('0, 0, 7, 0);

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        for (int n = 0; n < vecs.size(); n++) run_frame(vecs[n]);

        // Key 20 two frames into debounce, then asynchronous reset mid-frame.
        begin
            vec_t v;
            v.mask = k(20); v.pulse = 0; v.code = 5'd7; v.pressed = 0;
            run_frame(v);
            run_frame(v);
            repeat (6) @(negedge clk);
            #10 rst = 1'b1;
            #1 check_reset_outputs("async reset");
            @(negedge clk);
            check_reset_outputs("held reset");
            rst = 1'b0;
            v.code = 5'd0;
            run_frame(v);
            run_frame(v);
            v.pulse = 1; v.code = 5'd20; v.pressed = 1;
            run_frame(v);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/key_scan.md
Name: key_scan

Overview:
- Matrix keypad scanner for the 4-column x 5-row key pad on the 10 MHz system clock.
- Drives the column lines active-low, one column at a time, and samples the 5 active-low row returns.
- Debounces the per-frame result and reports each new single-key press as a 5-bit key code with a one-cycle valid strobe.
- Sits directly upstream of key decode/application logic.
- Its key_in is fed by the keypad row outputs; its column outputs drive the keypad column inputs.

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven (dwell). Legal range 2..65535. Default gives 100 us per column, 400 us per frame.
- DEBOUNCE_CNT, 20: number of consecutive identical frame results required to commit. Legal range 1..255.

Ports:
- clk  input  1  10 MHz system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- key_in  input  5  row returns, active low; bit r low means a key is closed in row r of the driven column.
- key_column_out  output  4  column drive, one-hot active low.
- key_code  output  5  last committed key code: 1..20, or 0 after reset.
- key_valid  output  1  one-cycle pulse when key_code is updated with a new press.
- key_pressed  output  1  level, high while a committed single key is held.

Behaviour:
- Reset (async, rst=1):
  - key_column_out=4'b1110; dwell counter=0; column index=0.
  - Frame accumulator cleared; previous frame result=0; stable count=0; committed state=0.
  - key_code=0, key_valid=0, key_pressed=0.
  - Reset asserted mid-frame or mid-debounce discards all partial results.
- Column sequencing:
  - Column c drives key_column_out with bit c low, all others high: 1110, 1101, 1011, 0111.
  - The dwell counter runs 0..SCAN_DIV-1.
  - On count SCAN_DIV-1, the column index advances 3->0 (wrap) and the counter returns to 0.
- Sampling:
  - key_in is sampled only on the last dwell cycle of each column. This allows for the one-cycle registered row response plus settling.
  - Row r low in column c contributes key c*5+r+1. Column 0 yields 1..5, column 3 yields 16..20.
- Frame result, evaluated after the column-3 sample:
  - 0 = no row low in any column.
  - Code 1..20 = exactly one low row bit across the whole frame.
  - 31 = two or more low bits in the frame (multi-key or ghost).
  - The accumulator clears for the next frame.
- Debounce:
  - If the frame result equals the previous frame result, stable count increments, saturating at DEBOUNCE_CNT.
  - Otherwise stable count = 1 and the previous frame result is replaced.
  - Commit happens on the frame where stable count first reaches DEBOUNCE_CNT. A saturated count never re-commits.
  - With DEBOUNCE_CNT=1, every changed result commits immediately.
- Commit actions (committed state <= stable result):
  - Result 1..20 and different from committed state: key_code <= result, key_valid=1 for exactly one cycle (the cycle after the frame-end sample), key_pressed=1.
  - Result 1..20 and equal to committed state: no action. Unreachable except after a glitch shorter than debounce.
  - Result 0: key_pressed=0, key_code holds, no pulse.
  - Result 31: key_pressed=0, key_code holds, no pulse. A following single key commits as a new press even if it equals key_code.
- Latency: a clean press stable from frame k produces key_valid one cycle after the column-3 sample of frame k+DEBOUNCE_CNT-1.
- key_valid is never high for two consecutive cycles.
- Rows all high (1'b1 per bit) or X-free undriven pull-ups are treated as no key.

Test Plan:
- Reset, then idle rows 11111 for 3 frames -> key_column_out cycles 1110,1101,1011,0111 with each phase exactly SCAN_DIV cycles; key_code=0, key_valid=0, key_pressed=0 throughout.
- SCAN_DIV=4, DEBOUNCE_CNT=3. Rows return 11011 only while column 2 is driven, held for 5 frames -> single key_valid pulse after the 3rd frame end, key_code=13, key_pressed=1. Release for 3 frames -> key_pressed=0, key_code stays 13, no pulse.
- Bouncing press: column 0 row 0 (code 1) present in alternating frames for 6 frames, then stable -> no pulse during bounce; exactly one pulse with key_code=1 after 3 stable frames.
- Two rows low in column 0 (rows 01110) stable -> frame result 31, no key_valid, key_pressed=0. Then a single code-1 key stable -> pulse with key_code=1.
- Keys in column 1 (row 0) and column 3 (row 0) simultaneously -> multi-key result 31, no pulse. Repeated same key 7 (press, release, press) -> two separate pulses, both key_code=7.
- Assert rst mid-frame with a key held two frames into debounce -> all outputs return to reset values immediately (asynchronous). After release of rst, a full DEBOUNCE_CNT frames are required before the pulse.
